// File: rtl/systolic_feeder_if.sv
// Beat input and skewed array-edge bundle between the K-slice source, the feeder and the array.
// The slave modport is the feeder side; the master modport is the source/observer side.
interface systolic_feeder_if #(
   parameter int LANES = 8,
   parameter int DW    = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_last;
   logic [LANES*DW-1:0]   a_col;
   logic [LANES*DW-1:0]   b_row;
   logic [LANES*DW-1:0]   aleft;
   logic [LANES*DW-1:0]   bup;
   logic [LANES-1:0]      enleft;
   logic [LANES-1:0]      enup;
   logic [LANES-1:0]      cmleft;
   logic [LANES-1:0]      cmup;

   modport master (
      output in_valid, in_last, a_col, b_row,
      input  in_ready, aleft, bup, enleft, enup, cmleft, cmup
   );

   modport slave (
      input  in_valid, in_last, a_col, b_row,
      output in_ready, aleft, bup, enleft, enup, cmleft, cmup
   );
endinterface

// File: rtl/systolic_feeder.sv
// Skews K-slice beats onto the systolic array edges: lane i lags acceptance by i+1 cycles.
// in_ready drops for the LANES drain cycles after a last beat; done pulses the cycle after.
module systolic_feeder #(
   parameter int LANES = 8,
   parameter int DW    = 32,
   parameter int CW    = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   systolic_feeder_if.slave  io_feed,
   output logic              o_busy,
   output logic              o_done,
   output logic [CW-1:0]     o_beat_cnt
);
   localparam int DCW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

   typedef struct packed {
      logic          en;
      logic          cm;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } slot_t;

   state_t          r_state, w_state_nxt;
   logic [DCW-1:0]  r_drain_cnt, w_drain_cnt_nxt;
   logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
   logic            r_done, w_done_nxt;
   logic            w_ready;
   logic            w_acc;

   assign w_ready = (r_state != S_DRAIN);
   assign w_acc   = io_feed.in_valid & w_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_drain_cnt <= '0;
         r_beat_cnt  <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
         r_beat_cnt  <= w_beat_cnt_nxt;
         r_done      <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_drain_cnt_nxt = r_drain_cnt;
      w_beat_cnt_nxt  = r_beat_cnt;
      w_done_nxt      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_acc) begin
               w_beat_cnt_nxt = CW'(1);
               if (io_feed.in_last) begin
                  w_state_nxt     = S_DRAIN;
                  w_drain_cnt_nxt = DCW'(LANES - 1);
               end else begin
                  w_state_nxt = S_STREAM;
               end
            end
         end
         S_STREAM: begin
            if (w_acc) begin
               if (r_beat_cnt != '1) w_beat_cnt_nxt = r_beat_cnt + CW'(1);
               if (io_feed.in_last) begin
                  w_state_nxt     = S_DRAIN;
                  w_drain_cnt_nxt = DCW'(LANES - 1);
               end
            end
         end
         S_DRAIN: begin
            // The last beat reaches the deepest lane while the count runs down.
            if (r_drain_cnt == '0) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_drain_cnt_nxt = r_drain_cnt - DCW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      slot_t r_chain [0:gi];
      slot_t w_in;

      // Data is zeroed on bubbles so the array never sees stale words.
      always_comb begin
         w_in.en = w_acc;
         w_in.cm = w_acc & io_feed.in_last;
         w_in.a  = w_acc ? io_feed.a_col[gi*DW +: DW] : '0;
         w_in.b  = w_acc ? io_feed.b_row[gi*DW +: DW] : '0;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int k = 0; k <= gi; k++) r_chain[k] <= '0;
         end else begin
            r_chain[0] <= w_in;
            for (int k = 1; k <= gi; k++) r_chain[k] <= r_chain[k-1];
         end
      end

      assign io_feed.aleft[gi*DW +: DW] = r_chain[gi].a;
      assign io_feed.bup[gi*DW +: DW]   = r_chain[gi].b;
      assign io_feed.enleft[gi]         = r_chain[gi].en;
      assign io_feed.enup[gi]           = r_chain[gi].en;
      assign io_feed.cmleft[gi]         = r_chain[gi].cm;
      assign io_feed.cmup[gi]           = r_chain[gi].cm;
   end

   assign io_feed.in_ready = w_ready;
   assign o_busy           = (r_state != S_IDLE);
   assign o_done           = r_done;
   assign o_beat_cnt       = r_beat_cnt;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: per-cycle edge/handshake checks plus hand-computed spot values.
module tb_systolic_feeder;
   localparam int LANES = 8;
   localparam int DW    = 32;
   localparam int CW    = 16;
   localparam int W     = LANES * DW;
   localparam int MAXC  = 64;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          busy;
   logic          done;
   logic [CW-1:0] beat_cnt;

   systolic_feeder_if #(.LANES(LANES), .DW(DW)) bus ();

   systolic_feeder #(.LANES(LANES), .DW(DW), .CW(CW)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .io_feed    (bus),
      .o_busy     (busy),
      .o_done     (done),
      .o_beat_cnt (beat_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic         s_vld [MAXC];
   logic         s_lst [MAXC];
   logic [W-1:0] s_a   [MAXC];
   logic [W-1:0] s_b   [MAXC];

   logic         h_acc [MAXC];
   logic         h_lst [MAXC];
   logic [W-1:0] h_a   [MAXC];
   logic [W-1:0] h_b   [MAXC];

   logic [W-1:0]     g_al [MAXC];
   logic [LANES-1:0] g_cm [MAXC];

   int            last_c;
   logic          in_stream;
   logic [CW-1:0] bc;
   int            done_at;
   int            done_n;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [DW-1:0] base);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < LANES; i++) v[i*DW +: DW] = base + DW'(i);
      return v;
   endfunction

   task automatic clr();
      for (int t = 0; t < MAXC; t++) begin
         s_vld[t] = 1'b0;
         s_lst[t] = 1'b0;
         s_a[t]   = '0;
         s_b[t]   = '0;
      end
   endtask

   // Entered and left at posedge+1; each iteration is one clock cycle, sampled at the negedge.
   task automatic run(input int n);
      int               d;
      int               s;
      logic             e_rdy, e_acc, e_busy;
      logic [W-1:0]     e_al, e_bu;
      logic [LANES-1:0] e_en, e_cm;
      last_c    = -100;
      in_stream = 1'b0;
      done_at   = -1;
      done_n    = 0;
      for (int t = 0; t < n; t++) begin
         bus.in_valid = s_vld[t];
         bus.in_last  = s_lst[t];
         bus.a_col    = s_a[t];
         bus.b_row    = s_b[t];
         @(negedge clk);
         d      = t - last_c;
         e_rdy  = !(d >= 1 && d <= 8);
         e_acc  = s_vld[t] & e_rdy;
         e_busy = in_stream || (d >= 1 && d <= 8);
         h_acc[t] = e_acc;
         h_lst[t] = e_acc & s_lst[t];
         h_a[t]   = s_a[t];
         h_b[t]   = s_b[t];
         e_al = '0; e_bu = '0; e_en = '0; e_cm = '0;
         for (int i = 0; i < LANES; i++) begin
            s = t - 1 - i;
            if (s >= 0 && h_acc[s]) begin
               e_en[i] = 1'b1;
               e_cm[i] = h_lst[s];
               e_al[i*DW +: DW] = h_a[s][i*DW +: DW];
               e_bu[i*DW +: DW] = h_b[s][i*DW +: DW];
            end
         end
         chk($sformatf("in_ready@%0d", t), W'(bus.in_ready), W'(e_rdy));
         chk($sformatf("done@%0d", t), W'(done), W'(d == 9));
         chk($sformatf("busy@%0d", t), W'(busy), W'(e_busy));
         chk($sformatf("beat_cnt@%0d", t), W'(beat_cnt), W'(bc));
         chk($sformatf("aleft@%0d", t), bus.aleft, e_al);
         chk($sformatf("bup@%0d", t), bus.bup, e_bu);
         chk($sformatf("enleft@%0d", t), W'(bus.enleft), W'(e_en));
         chk($sformatf("enup@%0d", t), W'(bus.enup), W'(e_en));
         chk($sformatf("cmleft@%0d", t), W'(bus.cmleft), W'(e_cm));
         chk($sformatf("cmup@%0d", t), W'(bus.cmup), W'(e_cm));
         g_al[t] = bus.aleft;
         g_cm[t] = bus.cmleft;
         if (done) begin
            done_n++;
            if (done_at < 0) done_at = t;
         end
         if (e_acc) begin
            bc = in_stream ? ((bc == '1) ? bc : bc + CW'(1)) : CW'(1);
            if (s_lst[t]) begin
               last_c    = t;
               in_stream = 1'b0;
            end else begin
               in_stream = 1'b1;
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.a_col    = '0;
      bus.b_row    = '0;
      bc           = '0;

      #12;
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_beat_cnt", W'(beat_cnt), W'(0));
      chk("rst_aleft", bus.aleft, '0);
      chk("rst_bup", bus.bup, '0);
      chk("rst_en", W'({bus.enleft, bus.enup}), W'(0));
      chk("rst_cm", W'({bus.cmleft, bus.cmup}), W'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rel_ready", W'(bus.in_ready), W'(1));
      @(posedge clk);
      #1;

      // Single-beat tile
      clr();
      s_vld[0] = 1'b1; s_lst[0] = 1'b1;
      s_a[0] = mk(32'h100); s_b[0] = mk(32'h200);
      run(14);
      chk("t1_done_at", W'(done_at), W'(9));
      chk("t1_done_n", W'(done_n), W'(1));
      chk("t1_beat_cnt", W'(beat_cnt), W'(1));

      // Four back-to-back beats, beat k carries k*16+i on lane i
      clr();
      for (int k = 0; k < 4; k++) begin
         s_vld[k] = 1'b1;
         s_a[k]   = mk(DW'(k * 16));
         s_b[k]   = mk(DW'(32'h200 + k * 16));
      end
      s_lst[3] = 1'b1;
      run(16);
      chk("t2_done_at", W'(done_at), W'(12));
      chk("t2_beat_cnt", W'(beat_cnt), W'(4));
      chk("t2_l3_c4", W'(g_al[4][3*DW +: DW]), W'(32'h03));
      chk("t2_l3_c7", W'(g_al[7][3*DW +: DW]), W'(32'h33));
      chk("t2_cm3_c7", W'(g_cm[7][3]), W'(1));
      chk("t2_cm3_c6", W'(g_cm[6][3]), W'(0));

      // Bubble at cycle 1, with a stray in_last that must be ignored
      clr();
      s_vld[0] = 1'b1; s_a[0] = mk(32'h10); s_b[0] = mk(32'h20);
      s_lst[1] = 1'b1;
      s_vld[2] = 1'b1; s_lst[2] = 1'b1; s_a[2] = mk(32'h30); s_b[2] = mk(32'h40);
      run(16);
      chk("t3_done_at", W'(done_at), W'(11));
      chk("t3_beat_cnt", W'(beat_cnt), W'(2));

      // Second tile starts in the first tile's done cycle
      clr();
      s_vld[0]  = 1'b1; s_a[0]  = mk(32'h400); s_b[0]  = mk(32'h480);
      s_vld[1]  = 1'b1; s_a[1]  = mk(32'h410); s_b[1]  = mk(32'h490); s_lst[1] = 1'b1;
      s_vld[10] = 1'b1; s_a[10] = mk(32'h420); s_b[10] = mk(32'h4a0);
      s_vld[11] = 1'b1; s_a[11] = mk(32'h430); s_b[11] = mk(32'h4b0); s_lst[11] = 1'b1;
      run(24);
      chk("t4_done_at", W'(done_at), W'(10));
      chk("t4_done_n", W'(done_n), W'(2));
      chk("t4_beat_cnt", W'(beat_cnt), W'(2));

      // Valid+last held through DRAIN; only the done-cycle copy is taken
      clr();
      s_vld[0] = 1'b1; s_lst[0] = 1'b1; s_a[0] = mk(32'h500); s_b[0] = mk(32'h580);
      for (int k = 1; k < 10; k++) begin
         s_vld[k] = 1'b1; s_lst[k] = 1'b1;
         s_a[k] = mk(32'h600); s_b[k] = mk(32'h680);
      end
      run(24);
      chk("t5_done_at", W'(done_at), W'(9));
      chk("t5_done_n", W'(done_n), W'(2));
      chk("t5_beat_cnt", W'(beat_cnt), W'(1));

      // Async reset in cycle 5 of an 8-beat tile
      clr();
      for (int k = 0; k < 8; k++) begin
         s_vld[k] = 1'b1;
         s_a[k]   = mk(DW'(32'h700 + k * 16));
         s_b[k]   = mk(DW'(32'h800 + k * 16));
      end
      s_lst[7] = 1'b1;
      run(5);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      #1;
      chk("t6_aleft", bus.aleft, '0);
      chk("t6_bup", bus.bup, '0);
      chk("t6_en", W'({bus.enleft, bus.enup}), W'(0));
      chk("t6_cm", W'({bus.cmleft, bus.cmup}), W'(0));
      chk("t6_busy", W'(busy), W'(0));
      chk("t6_done", W'(done), W'(0));
      chk("t6_beat_cnt", W'(beat_cnt), W'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bc    = '0;
      clr();
      run(14);
      chk("t6_done_n", W'(done_n), W'(0));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
